// File: rtl/riscv_pkg.sv
// Shared core definitions: register index width, hazard FSM states and
// the default data-memory wait limit.
package riscv_pkg;

   localparam int REGW = 5;

   localparam int DMEM_MAX_WAIT = 15;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } hazard_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks an outstanding data-memory access: raises mem_stall until ack and
// aborts with a bus error once MAX_WAIT wait cycles have passed without one.
module mem_wait_fsm
   import riscv_pkg::*;
#(
   parameter int MAX_WAIT = DMEM_MAX_WAIT,
   parameter int WCNT_W   = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic mem_req_m,
   input  logic dmem_ack_i,
   output logic mem_stall_o,
   output logic suppress_wb_o,
   output logic bus_err_o
);

   localparam logic [WCNT_W-1:0] CNT_MAX = WCNT_W'(MAX_WAIT);

   hazard_state_e     state;
   hazard_state_e     next_state;
   logic [WCNT_W-1:0] cnt;
   logic [WCNT_W-1:0] next_cnt;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // cnt counts wait cycles already spent; an ack always beats a timeout.
   always_comb begin
      next_state    = state;
      next_cnt      = cnt;
      mem_stall_o   = 1'b0;
      suppress_wb_o = 1'b0;
      bus_err_o     = 1'b0;
      case (state)
         IDLE: begin
            if (mem_req_m && !dmem_ack_i) begin
               mem_stall_o = 1'b1;
               next_state  = WAIT;
               next_cnt    = WCNT_W'(1);
            end
         end
         WAIT: begin
            if (dmem_ack_i) begin
               next_state = IDLE;
               next_cnt   = '0;
            end else if (cnt == CNT_MAX) begin
               bus_err_o     = 1'b1;
               suppress_wb_o = 1'b1;
               next_state    = IDLE;
               next_cnt      = '0;
            end else begin
               mem_stall_o = 1'b1;
               next_cnt    = cnt + WCNT_W'(1);
            end
         end
         default: begin
            next_state = IDLE;
            next_cnt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 3-stage core: operand forwarding, memory-wait
// stalls, branch flush. Optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int MAX_WAIT = DMEM_MAX_WAIT,
   parameter int WCNT_W   = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [REGW-1:0] rs1_e,
   input  logic [REGW-1:0] rs2_e,
   input  logic [REGW-1:0] rd_m,
   input  logic            reg_write_m,
   input  logic            mem_req_m,
   input  logic            dmem_ack_i,
   input  logic            branch_taken_e,
   output logic            fwd_a_o,
   output logic            fwd_b_o,
   output logic            stall_f_o,
   output logic            stall_e_o,
   output logic            flush_f_o,
   output logic            suppress_wb_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic            bus_err_o,
   output logic [31:0]     stall_cycles_o,
   output logic [31:0]     flush_count_o
`else
   output logic            bus_err_o
`endif
);

   logic mem_stall;

   mem_wait_fsm #(
      .MAX_WAIT (MAX_WAIT),
      .WCNT_W   (WCNT_W)
   ) u_fsm (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .mem_req_m     (mem_req_m),
      .dmem_ack_i    (dmem_ack_i),
      .mem_stall_o   (mem_stall),
      .suppress_wb_o (suppress_wb_o),
      .bus_err_o     (bus_err_o)
   );

   // x0 is hardwired to zero, so it is never forwarded.
   always_comb begin
      fwd_a_o = reg_write_m && (rs1_e == rd_m) && (rs1_e != '0);
      fwd_b_o = reg_write_m && (rs2_e == rd_m) && (rs2_e != '0);
   end

   // A branch in frozen E waits; its flush fires when the stall releases.
   always_comb begin
      stall_f_o = mem_stall;
      stall_e_o = mem_stall;
      flush_f_o = branch_taken_e && !mem_stall;
   end

`ifdef HAZARD_PERF_CNT_EN
   // Saturating event counters.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cycles_o <= '0;
         flush_count_o  <= '0;
      end else begin
         if (mem_stall && (stall_cycles_o != '1))
            stall_cycles_o <= stall_cycles_o + 32'd1;
         if (flush_f_o && (flush_count_o != '1))
            flush_count_o <= flush_count_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=4); covers the
// HAZARD_PERF_CNT_EN counters when the macro is defined.
module tb_pipeline_hazard_ctrl;
   import riscv_pkg::*;

   localparam int TB_MAX_WAIT = 4;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic [REGW-1:0] rs1_e = '0;
   logic [REGW-1:0] rs2_e = '0;
   logic [REGW-1:0] rd_m = '0;
   logic            reg_write_m = 1'b0;
   logic            mem_req_m = 1'b0;
   logic            dmem_ack_i = 1'b0;
   logic            branch_taken_e = 1'b0;
   logic            fwd_a_o, fwd_b_o, stall_f_o, stall_e_o;
   logic            flush_f_o, suppress_wb_o, bus_err_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0]     stall_cycles_o, flush_count_o;
`endif

   int compared = 0;
   int mismatched = 0;

   pipeline_hazard_ctrl #(
      .MAX_WAIT (TB_MAX_WAIT),
      .WCNT_W   (8)
   ) u_dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .rs1_e          (rs1_e),
      .rs2_e          (rs2_e),
      .rd_m           (rd_m),
      .reg_write_m    (reg_write_m),
      .mem_req_m      (mem_req_m),
      .dmem_ack_i     (dmem_ack_i),
      .branch_taken_e (branch_taken_e),
      .fwd_a_o        (fwd_a_o),
      .fwd_b_o        (fwd_b_o),
      .stall_f_o      (stall_f_o),
      .stall_e_o      (stall_e_o),
      .flush_f_o      (flush_f_o),
      .suppress_wb_o  (suppress_wb_o),
`ifdef HAZARD_PERF_CNT_EN
      .bus_err_o      (bus_err_o),
      .stall_cycles_o (stall_cycles_o),
      .flush_count_o  (flush_count_o)
`else
      .bus_err_o      (bus_err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Advance to just after the next rising edge, where inputs are changed.
   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_mem(input logic req, input logic ack, input logic br);
      mem_req_m      = req;
      dmem_ack_i     = ack;
      branch_taken_e = br;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      drive_mem(1'b0, 1'b0, 1'b0);
      #20;
      compared++;
      if ({fwd_a_o, fwd_b_o, stall_f_o, stall_e_o, flush_f_o, suppress_wb_o, bus_err_o} !== 7'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got %b expected 0000000",
                  {fwd_a_o, fwd_b_o, stall_f_o, stall_e_o, flush_f_o, suppress_wb_o, bus_err_o});
      end
      compared++;
      if (u_dut.u_fsm.state !== IDLE) begin
         mismatched++;
         $display("[TB] FAIL reset_state: got %0d expected IDLE", u_dut.u_fsm.state);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      next_cycle();
   endtask

   task automatic test_forwarding();
      logic [REGW-1:0] v_rs1 [6] = '{5'd5, 5'd0, 5'd7, 5'd3, 5'd9, 5'd12};
      logic [REGW-1:0] v_rs2 [6] = '{5'd5, 5'd0, 5'd8, 5'd7, 5'd9, 5'd12};
      logic [REGW-1:0] v_rd  [6] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd9, 5'd1};
      logic            v_we  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [1:0]      v_exp [6] = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
      for (int i = 0; i < 6; i++) begin
         rs1_e = v_rs1[i];
         rs2_e = v_rs2[i];
         rd_m = v_rd[i];
         reg_write_m = v_we[i];
         #1;
         compared++;
         if ({fwd_a_o, fwd_b_o} !== v_exp[i]) begin
            mismatched++;
            $display("[TB] FAIL fwd_vec%0d: got a,b=%b expected %b", i, {fwd_a_o, fwd_b_o}, v_exp[i]);
         end
      end
      rs1_e = '0; rs2_e = '0; rd_m = '0; reg_write_m = 1'b0;
      next_cycle();
   endtask

   task automatic test_stall_ack();
      for (int i = 0; i < 3; i++) begin
         drive_mem(1'b1, 1'b0, 1'b0);
         compared++;
         if ({stall_f_o, stall_e_o} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL stall_wait%0d: got f,e=%b expected 11", i, {stall_f_o, stall_e_o});
         end
         next_cycle();
      end
      drive_mem(1'b1, 1'b1, 1'b0);
      compared++;
      if ({stall_f_o, stall_e_o, bus_err_o} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL stall_ack_cycle: got f,e,err=%b expected 000", {stall_f_o, stall_e_o, bus_err_o});
      end
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b0);
      compared++;
      if (u_dut.u_fsm.state !== IDLE) begin
         mismatched++;
         $display("[TB] FAIL stall_return_idle: got %0d expected IDLE", u_dut.u_fsm.state);
      end
   endtask

   task automatic test_zero_wait();
      drive_mem(1'b1, 1'b1, 1'b0);
      compared++;
      if (stall_f_o !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL zero_wait_stall: got %b expected 0", stall_f_o);
      end
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b0);
      compared++;
      if (u_dut.u_fsm.state !== IDLE) begin
         mismatched++;
         $display("[TB] FAIL zero_wait_state: got %0d expected IDLE", u_dut.u_fsm.state);
      end
   endtask

   task automatic test_timeout(input logic ack_last);
      for (int i = 0; i < TB_MAX_WAIT; i++) begin
         drive_mem(1'b1, 1'b0, 1'b0);
         compared++;
         if (stall_f_o !== 1'b1 || bus_err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL timeout_wait%0d: got stall,err=%b%b expected 10", i, stall_f_o, bus_err_o);
         end
         next_cycle();
      end
      drive_mem(1'b1, ack_last, 1'b0);
      compared++;
      if ({stall_f_o, bus_err_o, suppress_wb_o} !== {1'b0, !ack_last, !ack_last}) begin
         mismatched++;
         $display("[TB] FAIL timeout_edge_ack%0d: got stall,err,sup=%b expected %b", ack_last,
                  {stall_f_o, bus_err_o, suppress_wb_o}, {1'b0, !ack_last, !ack_last});
      end
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b0);
      compared++;
      if ({bus_err_o, suppress_wb_o, stall_f_o} !== 3'b000 || u_dut.u_fsm.state !== IDLE) begin
         mismatched++;
         $display("[TB] FAIL timeout_after_ack%0d: got err,sup,stall=%b state=%0d expected 000 IDLE",
                  ack_last, {bus_err_o, suppress_wb_o, stall_f_o}, u_dut.u_fsm.state);
      end
   endtask

   task automatic test_branch_flush();
      for (int i = 0; i < 2; i++) begin
         drive_mem(1'b1, 1'b0, 1'b1);
         compared++;
         if ({stall_f_o, flush_f_o} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL flush_held%0d: got stall,flush=%b expected 10", i, {stall_f_o, flush_f_o});
         end
         next_cycle();
      end
      drive_mem(1'b1, 1'b1, 1'b1);
      compared++;
      if ({stall_f_o, flush_f_o} !== 2'b01) begin
         mismatched++;
         $display("[TB] FAIL flush_release: got stall,flush=%b expected 01", {stall_f_o, flush_f_o});
      end
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      drive_mem(1'b1, 1'b0, 1'b0);
      next_cycle();
      next_cycle();
      #2;
      rst_i = 1'b0;
      #1;
      compared++;
      if (u_dut.u_fsm.state !== IDLE || u_dut.u_fsm.cnt !== 8'd0) begin
         mismatched++;
         $display("[TB] FAIL async_reset_fsm: got state=%0d cnt=%0d expected IDLE 0",
                  u_dut.u_fsm.state, u_dut.u_fsm.cnt);
      end
      drive_mem(1'b0, 1'b0, 1'b0);
      compared++;
      if ({stall_f_o, stall_e_o, bus_err_o, suppress_wb_o, flush_f_o} !== 5'b0) begin
         mismatched++;
         $display("[TB] FAIL async_reset_outputs: got %b expected 00000",
                  {stall_f_o, stall_e_o, bus_err_o, suppress_wb_o, flush_f_o});
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      next_cycle();
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      rst_i = 1'b0;
      #3;
      rst_i = 1'b1;
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive_mem(1'b1, 1'b0, 1'b0);
         next_cycle();
      end
      drive_mem(1'b1, 1'b1, 1'b0);
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b1);
      next_cycle();
      drive_mem(1'b0, 1'b0, 1'b0);
      compared++;
      if (stall_cycles_o !== 32'd3 || flush_count_o !== 32'd1) begin
         mismatched++;
         $display("[TB] FAIL perf_counts: got stall=%0d flush=%0d expected 3 1", stall_cycles_o, flush_count_o);
      end
      rst_i = 1'b0;
      #1;
      compared++;
      if (stall_cycles_o !== 32'd0 || flush_count_o !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL perf_clear: got stall=%0d flush=%0d expected 0 0", stall_cycles_o, flush_count_o);
      end
      @(negedge clk_i);
      rst_i = 1'b1;
      next_cycle();
   endtask
`endif

   initial begin
      test_reset();
      test_forwarding();
      test_stall_ack();
      test_zero_wait();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_branch_flush();
      test_async_reset();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard controller for the 3-stage core (F, D/E, M/WB).
- Generates ALU operand-forward selects for RAW hazards, and sequences pipeline stalls while a variable-latency data-memory access completes.
- Flushes the fetch slot on taken branches and times out hung memory accesses.
- Sits beside the datapath; drives its stall/flush enables and the E-stage operand muxes.

Parameters:
- MAX_WAIT, 15, maximum consecutive wait cycles for one data-memory access before timeout (legal range 1..255).
- WCNT_W, 8, width of the wait counter; must satisfy 2^WCNT_W > MAX_WAIT.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  reset, asynchronous, active-low.
- rs1_e  input  REGW  rs1 of the instruction in E.
- rs2_e  input  REGW  rs2 of the instruction in E.
- rd_m  input  REGW  rd of the instruction in M/WB.
- reg_write_m  input  1  M/WB instruction writes the register file.
- mem_req_m  input  1  M/WB instruction is a load or store.
- dmem_ack_i  input  1  data memory completes the current access this cycle.
- branch_taken_e  input  1  E resolves a taken branch or jump.
- fwd_a_o  output  1  select M/WB result for ALU operand A.
- fwd_b_o  output  1  select M/WB result for ALU operand B.
- stall_f_o  output  1  hold PC and the F/E pipeline register.
- stall_e_o  output  1  hold the E/M pipeline register.
- flush_f_o  output  1  replace the F/E register contents with a NOP.
- suppress_wb_o  output  1  block the register-file write of the M/WB instruction.
- bus_err_o  output  1  one-cycle pulse on data-memory timeout.

Behaviour:
- Forwarding is combinational and does not depend on the FSM state.
  - fwd_a_o = reg_write_m & (rs1_e==rd_m) & (rs1_e!=0).
  - fwd_b_o = reg_write_m & (rs2_e==rd_m) & (rs2_e!=0).
  - Both outputs can be asserted at once and are evaluated independently.
- FSM states: IDLE, WAIT. Reset (rst_i=0) forces IDLE and cnt=0 immediately, including in the middle of an access.
- mem_stall (combinational):
  - IDLE: mem_stall = mem_req_m & !dmem_ack_i.
  - WAIT: mem_stall = !dmem_ack_i & (cnt != MAX_WAIT).
- IDLE transitions:
  - mem_req_m & !dmem_ack_i: go to WAIT, cnt <= 1.
  - Otherwise stay in IDLE. A zero-wait access (ack in the same cycle) never leaves IDLE.
- WAIT transitions:
  - dmem_ack_i: go to IDLE, cnt <= 0.
  - Else if cnt == MAX_WAIT: timeout. Assert bus_err_o and suppress_wb_o for this cycle, deassert stall, go to IDLE, cnt <= 0.
  - Otherwise cnt <= cnt + 1.
- Stall outputs: stall_f_o = stall_e_o = mem_stall. While stalled, the whole pipeline freezes and the M/WB instruction is held.
- Flush: flush_f_o = branch_taken_e & !mem_stall.
  - A branch in E during a memory stall is held, because E is frozen.
  - Its flush fires in the cycle the stall releases.
- Ack and timeout in the same cycle: ack wins. No error is raised.
- Forwarding during a stall may select a not-yet-valid M/WB result. This is harmless because E does not commit while stalled.
- Latency: stall asserts in the same cycle the request is seen without ack, and releases in the same cycle as the ack.
- Every output is 0 while in reset, provided the combinational inputs are 0.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output ports stall_cycles_o (32) and flush_count_o (32).
  - stall_cycles_o increments on every cycle with mem_stall=1.
  - flush_count_o increments on every cycle with flush_f_o=1.
  - Both counters saturate at 2^32-1 and clear on reset.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- riscv_pkg holds:
  - REGW (existing).
  - hazard_state_e enum {IDLE, WAIT}.
  - localparam DMEM_MAX_WAIT default.
- Sub-module mem_wait_fsm holds the FSM, wait counter, timeout, mem_stall and bus_err_o.
- The top level holds the forwarding compare, the flush gating and the optional counters.

Test Plan:
- rs1_e=5, rs2_e=5, rd_m=5, reg_write_m=1 -> fwd_a_o=1 and fwd_b_o=1. Same with rd_m=0, rs1_e=0, rs2_e=0 -> both 0.
- mem_req_m=1 with ack delayed 3 cycles -> stall_f_o/stall_e_o high for exactly 3 cycles, low in the ack cycle, FSM back in IDLE next cycle.
- mem_req_m=1, ack in the same cycle -> no stall, FSM stays IDLE.
- MAX_WAIT=4, no ack -> stall high for 4 cycles; in the 5th cycle bus_err_o=1, suppress_wb_o=1, stall=0; next cycle bus_err_o=0.
- branch_taken_e=1 during a 2-cycle memory stall -> flush_f_o=0 while stalled, then flush_f_o=1 in the release cycle. Ack and cnt==MAX_WAIT together -> bus_err_o=0.
- rst_i pulsed low mid-WAIT -> outputs drop and FSM returns to IDLE asynchronously. With HAZARD_PERF_CNT_EN defined, stall_cycles_o matches the count of stalled cycles and clears on reset.
